// File: rtl/cache_fill_gather.sv
// Collects in-order memory response beats into one cache line and presents it
// as a single registered fill request; holds exactly one line.
module cache_fill_gather #(
  parameter int LINE_SIZE       = 64,
  parameter int BEAT_SIZE       = 16,
  parameter int LINE_ADDR_WIDTH = 26
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mem_rsp_valid,
  input  logic [8*BEAT_SIZE-1:0]     mem_rsp_data,
  input  logic [LINE_ADDR_WIDTH-1:0] mem_rsp_tag,
  output logic                       mem_rsp_ready,
  output logic                       fill_valid,
  output logic [LINE_ADDR_WIDTH-1:0] fill_addr,
  output logic [8*LINE_SIZE-1:0]     fill_data,
  input  logic                       fill_ready,
  output logic                       busy,
  output logic                       tag_err
);

  localparam int NUM_BEATS = LINE_SIZE / BEAT_SIZE;
  localparam int BEAT_W    = 8 * BEAT_SIZE;
  localparam int LINE_W    = 8 * LINE_SIZE;
  localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;

  state_t                     r_state;
  logic [CNT_W-1:0]           r_cnt;
  logic [LINE_ADDR_WIDTH-1:0] r_addr;
  logic [LINE_W-1:0]          r_data;
  logic                       r_fill_valid;
  logic                       r_busy;
  logic                       r_tag_err;

  logic             w_ready;
  logic             w_acc;
  logic             w_start;
  logic             w_collect;
  logic             w_wr;
  logic [CNT_W-1:0] w_slot;

  // A held line only blocks new beats until the bank takes it in the same cycle.
  assign w_ready   = (r_state != FULL) || fill_ready;
  assign w_acc     = mem_rsp_valid && w_ready;
  assign w_start   = w_acc && (r_state != COLLECT);
  assign w_collect = w_acc && (r_state == COLLECT);
  assign w_wr      = w_start || w_collect;
  assign w_slot    = w_start ? '0 : r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_data       <= '0;
      r_fill_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_tag_err    <= 1'b0;
    end else begin
      r_tag_err <= 1'b0;
      for (int k = 0; k < NUM_BEATS; k++) begin
        if (w_wr && (w_slot == CNT_W'(k)))
          r_data[k*BEAT_W +: BEAT_W] <= mem_rsp_data;
      end
      if (w_start) begin
        r_addr <= mem_rsp_tag;
        if (NUM_BEATS == 1) begin
          r_state      <= FULL;
          r_cnt        <= '0;
          r_fill_valid <= 1'b1;
          r_busy       <= 1'b0;
        end else begin
          r_state      <= COLLECT;
          r_cnt        <= CNT_W'(1);
          r_fill_valid <= 1'b0;
          r_busy       <= 1'b1;
        end
      end else if (w_collect) begin
        // A mismatching beat is still stored; the line keeps its first-beat address.
        r_tag_err <= (mem_rsp_tag != r_addr);
        if (r_cnt == LAST_BEAT) begin
          r_state      <= FULL;
          r_cnt        <= '0;
          r_fill_valid <= 1'b1;
          r_busy       <= 1'b0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else if ((r_state == FULL) && fill_ready) begin
        r_state      <= IDLE;
        r_fill_valid <= 1'b0;
      end
    end
  end

  assign mem_rsp_ready = w_ready;
  assign fill_valid    = r_fill_valid;
  assign fill_addr     = r_addr;
  assign fill_data     = r_data;
  assign busy          = r_busy;
  assign tag_err       = r_tag_err;

endmodule

// File: tb/tb_cache_fill_gather.sv
// Randomized and directed bench for cache_fill_gather: a 4-beat instance and a
// single-beat instance, both checked each cycle against a transaction-level model.
module tb_cache_fill_gather;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         a_valid, a_ready, a_fv, a_fr, a_busy, a_err;
  logic [127:0] a_data;
  logic [25:0]  a_tag, a_faddr;
  logic [511:0] a_fdata;

  logic         b_valid, b_ready, b_fv, b_fr, b_busy, b_err;
  logic [511:0] b_data, b_fdata;
  logic [25:0]  b_tag, b_faddr;

  cache_fill_gather #(.LINE_SIZE(64), .BEAT_SIZE(16), .LINE_ADDR_WIDTH(26)) dut_a (
    .clk(clk), .reset(rst), .mem_rsp_valid(a_valid), .mem_rsp_data(a_data),
    .mem_rsp_tag(a_tag), .mem_rsp_ready(a_ready), .fill_valid(a_fv),
    .fill_addr(a_faddr), .fill_data(a_fdata), .fill_ready(a_fr),
    .busy(a_busy), .tag_err(a_err));

  cache_fill_gather #(.LINE_SIZE(64), .BEAT_SIZE(64), .LINE_ADDR_WIDTH(26)) dut_b (
    .clk(clk), .reset(rst), .mem_rsp_valid(b_valid), .mem_rsp_data(b_data),
    .mem_rsp_tag(b_tag), .mem_rsp_ready(b_ready), .fill_valid(b_fv),
    .fill_addr(b_faddr), .fill_data(b_fdata), .fill_ready(b_fr),
    .busy(b_busy), .tag_err(b_err));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model state: beats gathered into a line, a pending fill, a tag-error flag.
  bit           m_fv, m_err, mb_fv;
  int           m_cnt;
  logic [25:0]  m_addr, m_faddr, mb_faddr;
  logic [511:0] m_buf, m_fdata, mb_fdata;
  int           cyc = 0;

  initial begin : model
    bit acc, bacc;
    m_fv = 0; m_err = 0; m_cnt = 0; mb_fv = 0; m_buf = '0;
    forever begin
      @(posedge clk);
      cyc++;
      acc  = a_valid && (!m_fv || a_fr);
      bacc = b_valid && (!mb_fv || b_fr);
      if (rst) begin
        m_fv = 0; m_err = 0; m_cnt = 0; mb_fv = 0;
      end else begin
        m_err = 0;
        if (m_fv && a_fr) m_fv = 0;
        if (acc) begin
          if (m_cnt == 0) m_addr = a_tag;
          else if (a_tag != m_addr) m_err = 1;
          m_buf[m_cnt*128 +: 128] = a_data;
          m_cnt++;
          if (m_cnt == 4) begin
            m_cnt = 0; m_fv = 1; m_faddr = m_addr; m_fdata = m_buf;
          end
        end
        if (mb_fv && b_fr) mb_fv = 0;
        if (bacc) begin
          mb_fv = 1; mb_faddr = b_tag; mb_fdata = b_data;
        end
      end
    end
  end

  int          fills_a = 0, fills_b = 0, b_low = 0, b_first = 0, b_last = 0;
  logic [25:0] last_addr_a = '0, last_addr_b = '0;

  initial begin : compare
    forever begin
      @(negedge clk);
      chk("a_ready", a_ready, !m_fv || a_fr);
      chk("a_fill_valid", a_fv, m_fv);
      chk("a_busy", a_busy, m_cnt != 0);
      chk("a_tag_err", a_err, m_err);
      if (m_fv) begin
        chk("a_fill_addr", a_faddr, m_faddr);
        chk("a_fill_data", a_fdata, m_fdata);
      end
      if (a_fv && a_fr) begin fills_a++; last_addr_a = a_faddr; end
      chk("b_ready", b_ready, !mb_fv || b_fr);
      chk("b_fill_valid", b_fv, mb_fv);
      chk("b_busy", b_busy, 1'b0);
      if (mb_fv) begin
        chk("b_fill_addr", b_faddr, mb_faddr);
        chk("b_fill_data", b_fdata, mb_fdata);
      end
      if (b_fv && b_fr) begin
        if (fills_b == 0) b_first = cyc;
        b_last = cyc;
        fills_b++;
        last_addr_b = b_faddr;
      end
      if (!b_ready) b_low++;
    end
  end

  function automatic logic [127:0] pat(input int k);
    return {4{32'(k)}};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Offer one beat after `gap` idle cycles and hold it until accepted.
  task automatic send(input logic [25:0] tag, input logic [127:0] d, input int gap);
    bit acc;
    int n;
    a_valid = 1'b0;
    repeat (gap) step();
    a_valid = 1'b1; a_tag = tag; a_data = d; n = 0;
    do begin
      @(negedge clk); acc = a_ready;
      step(); n++;
    end while (!acc && n < 50);
    chk("send_accepted", acc, 1'b1);
    a_valid = 1'b0;
  endtask

  task automatic chk_words(input string nm);
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s_word%0d", nm, i), a_fdata[i*32 +: 32], 32'(i / 4));
  endtask

  bit rnd_done = 0;

  initial begin : main
    int f0;
    logic [25:0] tg, t;
    a_valid = 0; a_data = '0; a_tag = '0; a_fr = 1;
    b_valid = 0; b_data = '0; b_tag = '0; b_fr = 1;
    step(); step();
    @(negedge clk);
    chk("rst_ready_during", a_ready, 1'b1);
    step(); rst = 1'b0;
    @(negedge clk);
    chk("rst_fill_valid", a_fv, 1'b0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_tag_err", a_err, 1'b0);
    chk("rst_fill_addr", a_faddr, 26'h0);
    chk("rst_fill_data", a_fdata, 512'h0);
    chk("rst_ready_after", a_ready, 1'b1);
    step();

    // Back-to-back line, bank always ready.
    for (int k = 0; k < 4; k++) send(26'h12, pat(k), 0);
    @(negedge clk);
    chk("t1_fill_valid", a_fv, 1'b1);
    chk("t1_fill_addr", a_faddr, 26'h12);
    chk_words("t1");
    step();
    @(negedge clk);
    chk("t1_fill_drop", a_fv, 1'b0);
    step();

    // Bank stalls on a full line, then handshake and new first beat coincide.
    a_fr = 1'b0;
    for (int k = 0; k < 4; k++) send(26'h21, pat(k + 8), 0);
    a_valid = 1'b1; a_tag = 26'h13; a_data = pat(7);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t2_ready_low", a_ready, 1'b0);
      chk("t2_hold_valid", a_fv, 1'b1);
      chk("t2_hold_addr", a_faddr, 26'h21);
      chk("t2_hold_word0", a_fdata[31:0], 32'd8);
      step();
    end
    a_fr = 1'b1;
    @(negedge clk);
    chk("t2_ready_bypass", a_ready, 1'b1);
    step();
    a_valid = 1'b0;
    @(negedge clk);
    chk("t2_busy", a_busy, 1'b1);
    chk("t2_fill_gone", a_fv, 1'b0);
    step();
    for (int k = 1; k < 4; k++) send(26'h13, pat(k), 0);
    @(negedge clk);
    chk("t2_new_addr", a_faddr, 26'h13);
    step();

    // Same line with random gaps must assemble identically.
    for (int k = 0; k < 4; k++) send(26'h12, pat(k), $urandom_range(0, 3));
    @(negedge clk);
    chk("t3_fill_valid", a_fv, 1'b1);
    chk("t3_fill_addr", a_faddr, 26'h12);
    chk_words("t3");
    step();

    // Mismatching tag on beat 2.
    a_fr = 1'b0;
    send(26'h12, pat(16), 0);
    send(26'h12, pat(17), 0);
    send(26'h99, pat(18), 0);
    @(negedge clk);
    chk("t4_tag_err_pulse", a_err, 1'b1);
    step();
    @(negedge clk);
    chk("t4_tag_err_clear", a_err, 1'b0);
    step();
    send(26'h12, pat(19), 0);
    @(negedge clk);
    chk("t4_fill_valid", a_fv, 1'b1);
    chk("t4_fill_addr", a_faddr, 26'h12);
    chk("t4_slot2", a_fdata[256 +: 128], pat(18));
    a_fr = 1'b1;
    step();

    // Reset in the middle of a line discards it.
    f0 = fills_a;
    send(26'h30, pat(0), 0);
    send(26'h30, pat(1), 0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) send(26'h20, pat(k), 0);
    repeat (3) step();
    chk("t5_fill_count", 32'(fills_a - f0), 32'd1);
    chk("t5_fill_addr", last_addr_a, 26'h20);

    // Random lines, gaps, bank stalls and occasional tag errors.
    fork
      begin
        while (!rnd_done) begin
          step();
          a_fr = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        for (int l = 0; l < 24; l++) begin
          tg = 26'($urandom);
          for (int k = 0; k < 4; k++) begin
            t = (k > 0 && $urandom_range(0, 7) == 0) ? (tg ^ 26'h1) : tg;
            send(t, {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 3));
          end
        end
        rnd_done = 1;
      end
    join
    a_fr = 1'b1;
    repeat (5) step();

    // Single-beat lines at full throughput.
    f0 = fills_b;
    for (int i = 0; i < 8; i++) begin
      b_valid = 1'b1;
      b_tag = 26'h40 + 26'(i);
      for (int j = 0; j < 16; j++) b_data[j*32 +: 32] = $urandom;
      step();
    end
    b_valid = 1'b0;
    repeat (3) step();
    chk("t6_fill_count", 32'(fills_b - f0), 32'd8);
    chk("t6_consecutive", 32'(b_last - b_first), 32'd7);
    chk("t6_ready_never_low", 32'(b_low), 32'd0);
    chk("t6_last_addr", last_addr_b, 26'h47);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
